// File: rtl/nn_act_buffer.sv
`default_nettype none
// ============================================================================
// Module      : nn_act_buffer
// Description : Ping-pong activation buffer with saturating accumulate writes,
//               registered reads and a sequenced write-bank clear.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_act_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     write_enable,
    input  logic                     acc_mode,
    input  logic [ADDR_W-1:0]        read_addr,
    input  logic                     read_enable,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     rd_valid,
    input  logic                     swap,
    input  logic                     clear,
    output logic                     busy,
    output logic                     wbank,
    output logic                     err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] bank0 [DEPTH];
    logic signed [DATA_W-1:0] bank1 [DEPTH];

    logic [0:0]              state;
    logic [IDX_W-1:0]        clr_idx;
    logic                    swap_pending;

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    wr_accept;
    logic                    wr_oob;
    logic signed [DATA_W-1:0] old_word;
    logic signed [DATA_W-1:0] rd_word;
    logic [DATA_W:0]         sum_ext;
    logic signed [DATA_W-1:0] acc_word;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_idx;
    logic signed [DATA_W-1:0] mem_data;

    assign wr_in_range = ({1'b0, write_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, read_addr}  < DEPTH_EXT);
    assign wr_idx      = write_addr[IDX_W-1:0];
    assign rd_idx      = read_addr[IDX_W-1:0];

    assign busy      = (state == ST_CLEAR);
    assign wr_accept = write_enable & ~busy & wr_in_range;
    assign wr_oob    = write_enable & ~busy & ~wr_in_range;

    // Combinational read of the write bank makes accumulate a one-cycle RMW,
    // so back-to-back updates to one word always see the latest value.
    assign old_word = wbank ? bank1[wr_idx] : bank0[wr_idx];
    assign rd_word  = wbank ? bank0[rd_idx] : bank1[rd_idx];

    assign sum_ext = {old_word[DATA_W-1], old_word} + {data_in[DATA_W-1], data_in};

    always_comb begin
        acc_word = sum_ext[DATA_W-1:0];
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
            acc_word = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_idx  = wr_idx;
        mem_data = acc_mode ? acc_word : data_in;
        if (busy) begin
            mem_we   = 1'b1;
            mem_idx  = clr_idx;
            mem_data = '0;
        end else if (wr_accept) begin
            mem_we   = 1'b1;
        end
    end

    // Storage is deliberately not reset; an abandoned clear leaves a partial bank.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (wbank) begin
                bank1[mem_idx] <= mem_data;
            end else begin
                bank0[mem_idx] <= mem_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= read_enable;
            if (read_enable) begin
                data_out <= rd_in_range ? rd_word : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((read_enable && !rd_in_range) || wr_oob) begin
            err <= 1'b1;
        end
    end

    // Swaps seen during a clear are parked and applied on the first idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            clr_idx      <= '0;
            swap_pending <= 1'b0;
            wbank        <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (swap) begin
                swap_pending <= 1'b1;
            end
            if (clr_idx == LAST_IDX) begin
                state <= ST_IDLE;
            end else begin
                clr_idx <= clr_idx + IDX_W'(1);
            end
        end else begin
            if (clear) begin
                state   <= ST_CLEAR;
                clr_idx <= '0;
                if (swap) begin
                    swap_pending <= 1'b1;
                end
            end else if (swap || swap_pending) begin
                wbank        <= ~wbank;
                swap_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_act_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_act_buffer
// Description : Directed self-checking bench with a behavioural buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_act_buffer;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [AW-1:0]        write_addr = '0;
    logic signed [DW-1:0] data_in = '0;
    logic                 write_enable = 1'b0;
    logic                 acc_mode = 1'b0;
    logic [AW-1:0]        read_addr = '0;
    logic                 read_enable = 1'b0;
    logic signed [DW-1:0] data_out;
    logic                 rd_valid;
    logic                 swap = 1'b0;
    logic                 clear = 1'b0;
    logic                 busy;
    logic                 wbank;
    logic                 err;

    int checks = 0;
    int errors = 0;
    bit running = 1'b1;

    nn_act_buffer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .write_addr(write_addr), .data_in(data_in), .write_enable(write_enable),
        .acc_mode(acc_mode), .read_addr(read_addr), .read_enable(read_enable),
        .data_out(data_out), .rd_valid(rd_valid), .swap(swap), .clear(clear),
        .busy(busy), .wbank(wbank), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic signed [DW-1:0] m_mem [2][DP];
    bit                   m_known [2][DP];
    int                   m_wb = 0, m_pend = 0, m_clr_left = 0, m_err = 0, m_rv = 0;
    logic signed [DW-1:0] m_dout = '0;
    bit                   m_dout_known = 1'b1;

    function automatic logic signed [DW-1:0] sat_add(logic signed [DW-1:0] a, logic signed [DW-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'sd2147483647)  return 32'sh7FFFFFFF;
        if (s < -64'sd2147483648) return 32'sh80000000;
        return s[DW-1:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wb = 0; m_pend = 0; m_clr_left = 0; m_err = 0; m_rv = 0;
            m_dout = '0; m_dout_known = 1'b1;
        end else begin
            if (read_enable) begin
                m_rv = 1;
                if (read_addr < DP) begin
                    m_dout       = m_mem[1-m_wb][read_addr[4:0]];
                    m_dout_known = m_known[1-m_wb][read_addr[4:0]];
                end else begin
                    m_dout = '0; m_dout_known = 1'b1; m_err = 1;
                end
            end else begin
                m_rv = 0;
            end
            if (m_clr_left > 0) begin
                m_mem[m_wb][DP-m_clr_left]   = '0;
                m_known[m_wb][DP-m_clr_left] = 1'b1;
                m_clr_left = m_clr_left - 1;
                if (swap) m_pend = 1;
            end else begin
                if (write_enable) begin
                    if (write_addr < DP) begin
                        if (acc_mode)
                            m_mem[m_wb][write_addr[4:0]] = sat_add(m_mem[m_wb][write_addr[4:0]], data_in);
                        else begin
                            m_mem[m_wb][write_addr[4:0]]   = data_in;
                            m_known[m_wb][write_addr[4:0]] = 1'b1;
                        end
                    end else begin
                        m_err = 1;
                    end
                end
                if (clear) begin
                    m_clr_left = DP;
                    if (swap) m_pend = 1;
                end else if (swap || m_pend != 0) begin
                    m_wb = 1 - m_wb; m_pend = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            chk("cmp_rd_valid", 32'(rd_valid), 32'(m_rv));
            chk("cmp_busy",     32'(busy),     32'(m_clr_left > 0));
            chk("cmp_wbank",    32'(wbank),    32'(m_wb));
            chk("cmp_err",      32'(err),      32'(m_err));
            if (m_dout_known) chk("cmp_data_out", data_out, m_dout);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input bit acc);
        write_addr = AW'(a); data_in = d; acc_mode = acc; write_enable = 1'b1;
        tick;
        write_enable = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic do_swap;
        swap = 1'b1; tick; swap = 1'b0;
    endtask

    task automatic do_read(input int a, input logic [DW-1:0] exp, input string name);
        read_addr = AW'(a); read_enable = 1'b1;
        tick;
        read_enable = 1'b0;
        chk(name, data_out, exp);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic clear_and_wait(output int cnt);
        clear = 1'b1; tick; clear = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; tick; end
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_wbank",    32'(wbank),    32'd0);
        chk("reset_err",      32'(err),      32'd0);
        reset = 1'b0;

        // clear bank 0, count busy, read it back
        clear_and_wait(cnt);
        chk("busy_cycles", 32'(cnt), 32'd32);
        do_swap;
        do_read(5, 32'h0, "cleared_word");
        clear_and_wait(cnt);
        do_swap;

        // overwrite then back-to-back accumulates
        do_write(3, 32'h10, 1'b0);
        do_write(3, 32'h5, 1'b1);
        do_write(3, -32'sh2, 1'b1);
        do_swap;
        do_read(3, 32'h13, "acc_sum");

        // saturation in both directions
        do_write(0, 32'h7FFFFFF0, 1'b0);
        do_write(0, 32'h100, 1'b1);
        do_write(1, 32'h80000010, 1'b0);
        do_write(1, -32'sh100, 1'b1);
        do_swap;
        do_read(0, 32'h7FFFFFFF, "sat_pos");
        do_read(1, 32'h80000000, "sat_neg");

        // write + read coincident with swap use the pre-swap banks
        write_addr = 16'd7; data_in = 32'h55; write_enable = 1'b1;
        read_addr = 16'd0; read_enable = 1'b1; swap = 1'b1;
        tick;
        write_enable = 1'b0; read_enable = 1'b0; swap = 1'b0;
        chk("swap_read_pre", data_out, 32'h7FFFFFFF);
        chk("swap_wbank", 32'(wbank), 32'd1);
        do_read(7, 32'h55, "swap_write_pre");

        // out-of-range write and read
        do_write(40, 32'h99, 1'b0);
        do_read(40, 32'h0, "oob_read");
        chk("oob_err", 32'(err), 32'd1);
        repeat (3) tick;
        chk("err_sticky", 32'(err), 32'd1);
        do_swap;
        do_read(8, 32'h0, "oob_no_alias");
        reset = 1'b1; tick; reset = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // swap on 3rd busy cycle, dropped write on 10th
        clear = 1'b1; tick; clear = 1'b0;
        tick; tick;
        swap = 1'b1; tick; swap = 1'b0;
        cnt = 4;
        while (busy && cnt < 100) begin
            if (cnt == 10) begin
                write_addr = 16'd4; data_in = 32'h77; write_enable = 1'b1;
            end else begin
                write_enable = 1'b0;
            end
            cnt++;
            tick;
        end
        write_enable = 1'b0;
        chk("pend_busy_len", 32'(cnt), 32'd33);
        chk("pend_first_idle", 32'(wbank), 32'd0);
        tick;
        chk("pend_toggled", 32'(wbank), 32'd1);
        tick;
        chk("pend_once", 32'(wbank), 32'd1);
        chk("busy_write_no_err", 32'(err), 32'd0);
        do_read(4, 32'h0, "busy_write_dropped");

        // reset mid-clear leaves a partially cleared bank
        do_swap;
        for (int i = 0; i < DP; i++) begin
            write_addr = AW'(i); data_in = 32'(100 + i); write_enable = 1'b1;
            tick;
        end
        write_enable = 1'b0;
        do_write(50, 32'h1, 1'b0);
        clear = 1'b1; tick; clear = 1'b0;
        repeat (9) tick;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #2;
        chk("async_busy",  32'(busy),  32'd0);
        chk("async_wbank", 32'(wbank), 32'd0);
        chk("async_err",   32'(err),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_swap;
        for (int i = 0; i < DP; i++) begin
            read_addr = AW'(i); read_enable = 1'b1;
            tick;
            if (i == 8)  chk("partial_w8",  data_out, 32'h0);
            if (i == 9)  chk("partial_w9",  data_out, 32'd109);
            if (i == 31) chk("partial_w31", data_out, 32'd131);
        end
        read_enable = 1'b0;
        repeat (2) tick;

        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_act_buffer.md
NN_ACT_BUFFER -- requirements
Module: nn_act_buffer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning signed data word width.
REQ-002 The block SHALL take parameter DEPTH, default 32, meaning words per bank.
REQ-003 The block SHALL take parameter ADDR_W, default 16, meaning address port width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 write_addr  input  ADDR_W  write-bank word address.
REQ-007 data_in  input  DATA_W (signed)  write data.
REQ-008 write_enable  input  1  write strobe.
REQ-009 acc_mode  input  1  0 = overwrite, 1 = accumulate into addressed word.
REQ-010 read_addr  input  ADDR_W  read-bank word address.
REQ-011 read_enable  input  1  read strobe.
REQ-012 data_out  output  DATA_W (signed)  registered read data.
REQ-013 rd_valid  output  1  data_out valid this cycle.
REQ-014 swap  input  1  single-cycle request to exchange write and read banks.
REQ-015 clear  input  1  single-cycle request to zero the current write bank.
REQ-016 busy  output  1  clear sequence in progress.
REQ-017 wbank  output  1  index of current write bank; read bank = ~wbank.
REQ-018 err  output  1  sticky out-of-range flag.

Function
REQ-019 The block SHALL hold two banks of DEPTH x DATA_W signed words (ping-pong).
REQ-020 Write: write_enable=1, busy=0 and write_addr<DEPTH -> at the edge, overwrite (acc_mode=0) or accumulate (acc_mode=1) word at write_addr in bank wbank.
REQ-021 Accumulate SHALL be a single-cycle read-modify-write, stored value = old + data_in, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-022 Back-to-back accumulates to one address on consecutive cycles SHALL each see the previous cycle's result (no lost updates).
REQ-023 Read: read_enable=1 -> next cycle data_out = word read_addr of bank ~wbank, rd_valid=1; latency exactly 1.
REQ-024 read_enable=0 -> next cycle rd_valid=0, data_out holds previous value.
REQ-025 read_addr>=DEPTH with read_enable=1 -> next cycle data_out=0, rd_valid=1, err set.
REQ-026 write_addr>=DEPTH with write_enable=1 -> no memory change, err set.
REQ-027 err SHALL remain 1 until reset.
REQ-028 FSM states IDLE, CLEAR; IDLE->CLEAR on clear=1; CLEAR zeroes one word of bank wbank per cycle, address 0..DEPTH-1; CLEAR->IDLE after word DEPTH-1 written.
REQ-029 busy=1 exactly during CLEAR (DEPTH cycles); clear while busy SHALL be ignored.
REQ-030 Writes while busy SHALL be dropped (no err); reads continue normally during CLEAR.
REQ-031 swap=1 in IDLE with clear=0 -> wbank toggles at that edge.
REQ-032 swap during CLEAR, or coincident with clear, SHALL be latched pending and executed on the first IDLE cycle after CLEAR completes; multiple pending swaps collapse to one.
REQ-033 A write coincident with a swap SHALL land in the pre-swap wbank; a read coincident with a swap SHALL use the pre-swap read bank.

Reset
REQ-034 reset=1 SHALL immediately force data_out=0, rd_valid=0, busy=0, wbank=0, err=0, FSM=IDLE, pending swap cleared.
REQ-035 Memory contents SHALL not be reset; reset asserted mid-CLEAR abandons the sequence with bank partially cleared.

Verification
REQ-036 Reset, clear, wait 32 cycles, swap, read addr 5 -> busy high exactly 32 cycles; one cycle after read, data_out=0, rd_valid=1.
REQ-037 Overwrite addr 3=0x10, acc addr 3 +0x5 then +(-0x2), swap, read 3 -> data_out=0x13.
REQ-038 Overwrite addr 0=0x7FFFFFF0, acc +0x100, swap, read 0 -> data_out=0x7FFFFFFF; same with 0x80000010 + (-0x100) -> 0x80000000.
REQ-039 Write addr 40, then read addr 40 -> memory unchanged, data_out=0, rd_valid=1, err=1 held until reset.
REQ-040 Issue clear, assert swap on 3rd busy cycle -> wbank unchanged until busy falls, toggles exactly once next IDLE cycle.
REQ-041 Assert reset on 10th busy cycle -> busy=0, wbank=0, err=0 immediately; words 0..8 of bank 0 zero, others retain prior values.
